// File: rtl/recovery_response_buffer_if.sv
// Handshake bundle between the recovery command executor, the response
// buffer and the recovery TX stage.
interface recovery_response_buffer_if #(
  parameter int LenWidth = 16
);
  logic                wr_valid_i;
  logic                wr_ready_o;
  logic [7:0]          wr_data_i;
  logic                wr_last_i;
  logic                wr_abort_i;
  logic                replay_i;
  logic                res_valid_o;
  logic                res_ready_i;
  logic [LenWidth-1:0] res_len_o;
  logic                res_dvalid_o;
  logic                res_dready_i;
  logic [7:0]          res_data_o;
  logic                res_dlast_o;
  logic                overflow_o;
  logic                busy_o;

  modport master (
    output wr_valid_i, wr_data_i, wr_last_i,
    output wr_abort_i, replay_i,
    output res_ready_i, res_dready_i,
    input  wr_ready_o, res_valid_o, res_len_o,
    input  res_dvalid_o, res_data_o, res_dlast_o,
    input  overflow_o, busy_o
  );

  modport slave (
    input  wr_valid_i, wr_data_i, wr_last_i,
    input  wr_abort_i, replay_i,
    input  res_ready_i, res_dready_i,
    output wr_ready_o, res_valid_o, res_len_o,
    output res_dvalid_o, res_data_o, res_dlast_o,
    output overflow_o, busy_o
  );
endinterface

// File: rtl/recovery_response_buffer.sv
// Single-response recovery buffer: fill, announce length, stream bytes.
// Define RECOVERY_RESBUF_REPLAY_EN to keep the last response for replay.
module recovery_response_buffer #(
  parameter int Depth    = 256,
  parameter int LenWidth = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic soft_reset_ni,
  recovery_response_buffer_if.slave bus
);
  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);
  localparam logic [CW-1:0] Full = CW'(Depth);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    ANNOUNCE = 2'd1,
`ifdef RECOVERY_RESBUF_REPLAY_EN
    HOLD     = 2'd3,
`endif
    STREAM   = 2'd2
  } state_t;

  state_t              state;
  logic [7:0]          mem [Depth];
  logic [AW-1:0]       wr_ptr;
  logic [LenWidth-1:0] rd_ptr;
  logic [CW-1:0]       count;
  logic [LenWidth-1:0] len;
  logic                overflow;
  logic                wr_ready;
  logic                res_valid;
  logic                dvalid;
  logic                dlast;
  logic                wr_fire;
  logic                clr;
  logic [AW-1:0]       waddr;

  always_comb begin
    wr_ready  = 1'b0;
    res_valid = 1'b0;
    dvalid    = 1'b0;
    case (state)
      FILL:     wr_ready  = count < Full;
      ANNOUNCE: res_valid = 1'b1;
      STREAM:   dvalid    = rd_ptr < len;
`ifdef RECOVERY_RESBUF_REPLAY_EN
      HOLD:     wr_ready  = 1'b1;
`endif
      default:  ;
    endcase
  end

  assign dlast   = dvalid & (rd_ptr == len - LenWidth'(1));
  assign clr     = ~soft_reset_ni | bus.wr_abort_i;
  assign wr_fire = bus.wr_valid_i & wr_ready & ~clr;

`ifdef RECOVERY_RESBUF_REPLAY_EN
  // A write in Hold starts a fresh response at byte 0.
  assign waddr = (state == HOLD) ? '0 : wr_ptr;
`else
  logic replay_unused;
  assign replay_unused = bus.replay_i;
  assign waddr = wr_ptr;
`endif

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[waddr] <= bus.wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      len      <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      state    <= FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      len      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (bus.wr_valid_i && count == Full)
            overflow <= 1'b1;
          if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + CW'(1);
            if (bus.wr_last_i) begin
              len   <= LenWidth'(count) + LenWidth'(1);
              state <= ANNOUNCE;
            end
          end
        end
        ANNOUNCE: begin
          if (bus.res_ready_i) begin
            rd_ptr <= '0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (dvalid && bus.res_dready_i) begin
            if (dlast) begin
`ifdef RECOVERY_RESBUF_REPLAY_EN
              state  <= HOLD;
`else
              state  <= FILL;
              wr_ptr <= '0;
              count  <= '0;
`endif
            end else begin
              rd_ptr <= rd_ptr + LenWidth'(1);
            end
          end
        end
`ifdef RECOVERY_RESBUF_REPLAY_EN
        HOLD: begin
          if (bus.wr_valid_i) begin
            wr_ptr <= AW'(1);
            count  <= CW'(1);
            if (bus.wr_last_i) begin
              len   <= LenWidth'(1);
              state <= ANNOUNCE;
            end else begin
              state <= FILL;
            end
          end else if (bus.replay_i) begin
            state <= ANNOUNCE;
          end
        end
`endif
        default: state <= FILL;
      endcase
    end
  end

  assign bus.wr_ready_o   = wr_ready;
  assign bus.res_valid_o  = res_valid;
  assign bus.res_len_o    = len;
  assign bus.res_dvalid_o = dvalid;
  assign bus.res_dlast_o  = dlast;
  assign bus.res_data_o   = dvalid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign bus.overflow_o   = overflow;
  assign bus.busy_o       = (state != FILL) || (count != '0);
endmodule
